// File: rtl/axil_read_handler.sv
// axil_read_handler: AXI4-Lite read master, one AR/R transaction in flight for the HLS datapath.
// Latency: start accept to read_valid is 3 cycles with a zero-wait slave; every output is a flop.
// Backpressure: start_read ignored while ready=0; waits on arready/rvalid unless AXIL_READ_TIMEOUT_EN arms a watchdog.
module axil_read_handler #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic                  start_read,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  read_error,
  output logic [ADDR_WIDTH-1:0] s_axil_araddr,
  output logic [2:0]            s_axil_arprot,
  output logic                  s_axil_arvalid,
  input  logic                  s_axil_arready,
  input  logic [DATA_WIDTH-1:0] s_axil_rdata,
  input  logic [1:0]            s_axil_rresp,
  input  logic                  s_axil_rvalid,
  output logic                  s_axil_rready
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t state, state_nxt;
  logic   accept, ar_done, r_done, abort;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  assign accept  = (state == IDLE) && start_read;
  assign ar_done = (state == ADDR) && s_axil_arready;
  assign r_done  = (state == DATA) && s_axil_rvalid;

`ifdef AXIL_READ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wd_cnt;

  // Abort fires on the edge the count reaches TIMEOUT_CYCLES; a real response on that edge still wins.
  assign abort = (state != IDLE) && (wd_cnt == TO_LAST) && !r_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
    end else if (accept) begin
      wd_cnt <= '0;
    end else if (state != IDLE) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)  state_nxt = ADDR;
      ADDR:    if (ar_done) state_nxt = DATA;
      DATA:    if (r_done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Handshake outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready          <= 1'b1;
      s_axil_arvalid <= 1'b0;
      s_axil_rready  <= 1'b0;
      read_valid     <= 1'b0;
      read_error     <= 1'b0;
      read_data      <= '0;
      s_axil_araddr  <= '0;
    end else begin
      ready          <= (state_nxt == IDLE);
      s_axil_arvalid <= (state_nxt == ADDR);
      s_axil_rready  <= (state_nxt == DATA);
      read_valid     <= r_done || abort;
      if (accept) begin
        s_axil_araddr <= read_addr;
      end
      if (r_done) begin
        read_data  <= s_axil_rdata;
        read_error <= (s_axil_rresp != 2'b00);
      end else if (abort) begin
        read_data  <= '0;
        read_error <= 1'b1;
      end
    end
  end

  assign s_axil_arprot = 3'b000;

endmodule

// File: tb/tb_axil_read_handler.sv
// Randomized bench for axil_read_handler: a scheduled stub slave plus a timeline model of each read.
module tb_axil_read_handler;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int TO  = 16;
  localparam int BIG = 1 << 30;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] read_addr;
  logic          start_read;
  logic          ready;
  logic [DW-1:0] read_data;
  logic          read_valid;
  logic          read_error;
  logic [AW-1:0] s_axil_araddr;
  logic [2:0]    s_axil_arprot;
  logic          s_axil_arvalid;
  logic          s_axil_arready;
  logic [DW-1:0] s_axil_rdata;
  logic [1:0]    s_axil_rresp;
  logic          s_axil_rvalid;
  logic          s_axil_rready;

  axil_read_handler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .read_addr(read_addr), .start_read(start_read), .ready(ready),
    .read_data(read_data), .read_valid(read_valid), .read_error(read_error),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready)
  );

  always #5 clk = ~clk;

  // cyc equals the number of rising edges seen; read mid-cycle on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [32];
  int checks = 0;
  int errors = 0;

  // Model of the one read in flight: accept edge, slave delays, completion cycle, result.
  bit            mdl_on;
  bit            t_valid;
  int            t_n, t_da, t_dr, t_done, last_done;
  int            ar_cyc, r_cyc;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_data, held_data;
  logic          t_err;
  logic [1:0]    t_resp;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare();
    bit rv, arv, rr;
    logic [DW-1:0] exp_d;
    if (!mdl_on) return;
    rv  = t_valid && (cyc == t_done);
    arv = t_valid && cyc >= t_n && cyc <= t_n + t_da && cyc < t_done;
    rr  = t_valid && cyc >= t_n + t_da + 1 && cyc <= t_n + t_da + 1 + t_dr && cyc < t_done;
    chk("ready", ready, cyc >= last_done);
    chk("arvalid", s_axil_arvalid, arv);
    chk("rready", s_axil_rready, rr);
    chk("read_valid", read_valid, rv);
    chk("arprot", s_axil_arprot, 3'b000);
    exp_d = rv ? t_data : held_data;
    chk("read_data", read_data, exp_d);
    held_data = exp_d;
    if (rv) chk("read_error", read_error, t_err);
    if (arv) chk("araddr", s_axil_araddr, t_addr);
  endtask

  task automatic drive(input bit req, input logic [AW-1:0] addr, input int da, input int dr,
                       input logic [1:0] resp);
    start_read = req;
    read_addr  = req ? addr : AW'($urandom);
    if (req && cyc >= last_done) begin
      t_valid = 1'b1;
      t_n     = cyc + 1;
      t_da    = da;
      t_dr    = dr;
      t_addr  = addr;
      t_data  = mem[addr];
      t_err   = (resp != 2'b00);
      t_resp  = resp;
      t_done  = t_n + 2 + da + dr;
      ar_cyc  = t_n + da;
      r_cyc   = t_n + da + 1 + dr;
`ifdef AXIL_READ_TIMEOUT_EN
      if (da + dr + 2 > TO) begin
        t_done = t_n + TO;
        t_data = '0;
        t_err  = 1'b1;
        r_cyc  = BIG;
      end
`endif
      last_done = t_done;
    end
    if (t_valid && cyc >= t_n && cyc < ar_cyc) s_axil_arready = 1'b0;
    else if (t_valid && cyc == ar_cyc)         s_axil_arready = 1'b1;
    else                                       s_axil_arready = 1'($urandom);
    if (t_valid && cyc == r_cyc) begin
      s_axil_rvalid = 1'b1;
      s_axil_rdata  = mem[t_addr];
      s_axil_rresp  = t_resp;
    end else if (t_valid && cyc > ar_cyc && cyc < r_cyc) begin
      s_axil_rvalid = 1'b0;
      s_axil_rdata  = $urandom;
      s_axil_rresp  = 2'($urandom);
    end else begin
      // Stray R beats outside DATA must be ignored by the handler.
      s_axil_rvalid = ($urandom % 4) == 0;
      s_axil_rdata  = $urandom;
      s_axil_rresp  = 2'($urandom);
    end
  endtask

  task automatic step(input bit req, input logic [AW-1:0] addr, input int da, input int dr,
                      input logic [1:0] resp);
    @(negedge clk);
    compare();
    drive(req, addr, da, dr, resp);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 0, 0, 2'b00);
  endtask

  task automatic model_reset();
    t_valid   = 1'b0;
    ar_cyc    = BIG;
    r_cyc     = BIG;
    last_done = cyc;
    held_data = '0;
    mdl_on    = 1'b1;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[1] = 32'd2345;
    mem[2] = 32'd7;
    mem[3] = 32'hDEAD;
    mdl_on = 1'b0; t_valid = 1'b0; ar_cyc = BIG; r_cyc = BIG;
    rst = 1'b0; start_read = 1'b0; read_addr = '0;
    s_axil_arready = 1'b0; s_axil_rvalid = 1'b0; s_axil_rdata = '0; s_axil_rresp = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_arvalid", s_axil_arvalid, 1'b0);
    chk("rst_rready", s_axil_rready, 1'b0);
    chk("rst_read_valid", read_valid, 1'b0);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_araddr", s_axil_araddr, 5'd0);
    rst = 1'b1;
    model_reset();

    // Single read then a back-to-back read issued in the completion cycle.
    step(1'b1, 5'd1, 0, 0, 2'b00);
    n = t_n;
    idle(2);
    @(negedge clk);
    compare();
    chk("lat3_valid", read_valid, 1'b1);
    chk("lat3_data", read_data, 32'd2345);
    chk("lat3_err", read_error, 1'b0);
    drive(1'b1, 5'd2, 0, 0, 2'b00);
    n = t_n;
    @(negedge clk);
    compare();
    chk("b2b_pulse_end", read_valid, 1'b0);
    chk("b2b_arvalid", s_axil_arvalid, 1'b1);
    drive(1'b0, '0, 0, 0, 2'b00);
    idle(1);
    @(negedge clk);
    compare();
    chk("b2b_data", read_data, 32'd7);
    chk("b2b_valid", read_valid, 1'b1);
    drive(1'b0, '0, 0, 0, 2'b00);
    idle(3);

    // Address channel stalled five cycles.
    step(1'b1, 5'd4, 5, 1, 2'b00);
    n = t_n;
    idle(4);
    @(negedge clk);
    compare();
    chk("stall_arvalid", s_axil_arvalid, 1'b1);
    chk("stall_araddr", s_axil_araddr, 5'd4);
    chk("stall_rready", s_axil_rready, 1'b0);
    chk("stall_ready", ready, 1'b0);
    drive(1'b0, '0, 0, 0, 2'b00);
    idle(8);

    // SLVERR response.
    step(1'b1, 5'd3, 0, 0, 2'b10);
    idle(2);
    @(negedge clk);
    compare();
    chk("err_valid", read_valid, 1'b1);
    chk("err_flag", read_error, 1'b1);
    chk("err_data", read_data, 32'hDEAD);
    drive(1'b0, '0, 0, 0, 2'b00);
    idle(3);

    // Random requests, including requests while busy, stray beats and error responses.
    repeat (400) begin
      step(($urandom % 3) == 0, AW'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
           (($urandom % 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
    end
    idle(15);

    // Slave that never answers within 100 cycles.
    step(1'b1, 5'd5, 100, 0, 2'b00);
    n = t_n;
    idle(16);
    @(negedge clk);
    compare();
`ifdef AXIL_READ_TIMEOUT_EN
    chk("to_valid", read_valid, 1'b1);
    chk("to_err", read_error, 1'b1);
    chk("to_data", read_data, 32'd0);
    drive(1'b0, '0, 0, 0, 2'b00);
    @(negedge clk);
    compare();
    chk("to_ready", ready, 1'b1);
    drive(1'b0, '0, 0, 0, 2'b00);
    idle(95);
`else
    chk("hang_arvalid16", s_axil_arvalid, 1'b1);
    drive(1'b0, '0, 0, 0, 2'b00);
    idle(83);
    @(negedge clk);
    compare();
    chk("hang_arvalid100", s_axil_arvalid, 1'b1);
    drive(1'b0, '0, 0, 0, 2'b00);
    idle(6);
`endif

    // Reset while waiting in DATA.
    step(1'b1, 5'd6, 0, 20, 2'b00);
    n = t_n;
    idle(5);
    @(negedge clk);
    compare();
    chk("mid_rready", s_axil_rready, 1'b1);
    mdl_on = 1'b0;
    start_read = 1'b0;
    rst = 1'b0;
    #1;
    chk("mr_ready", ready, 1'b1);
    chk("mr_arvalid", s_axil_arvalid, 1'b0);
    chk("mr_rready", s_axil_rready, 1'b0);
    chk("mr_read_valid", read_valid, 1'b0);
    chk("mr_read_data", read_data, 32'd0);
    @(negedge clk);
    chk("mr2_ready", ready, 1'b1);
    chk("mr2_rready", s_axil_rready, 1'b0);
    rst = 1'b1;
    model_reset();
    step(1'b1, 5'd1, 0, 0, 2'b00);
    idle(2);
    @(negedge clk);
    compare();
    chk("post_rst_data", read_data, 32'd2345);
    drive(1'b0, '0, 0, 0, 2'b00);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
